// File: rtl/vedic_seq_pkg.sv
// Shared encoding and width helpers for the sequential Vedic multiplier front end.
package vedic_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACC1 = 3'd1,
    S_ACC2 = 3'd2,
    S_ACC3 = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam int N_DEF = 8;

  function automatic int half_w(input int n);
    return n / 2;
  endfunction

  function automatic int prod_w(input int n);
    return 2 * n;
  endfunction

  // Cross terms land h bits up; the high-high term lands N bits up.
  function automatic int sh_cross(input int n);
    return n / 2;
  endfunction

  function automatic int sh_high(input int n);
    return n;
  endfunction

  localparam int H_DEF        = half_w(N_DEF);
  localparam int P_DEF        = prod_w(N_DEF);
  localparam int SH_CROSS_DEF = sh_cross(N_DEF);
  localparam int SH_HIGH_DEF  = sh_high(N_DEF);

endpackage

// File: rtl/vedic_half_mult.sv
// Combinational WxW exact multiplier using Urdhva-Tiryagbhyam column sums
// (vertical/crosswise partial-product columns with rippled column carries).
module vedic_half_mult #(
  parameter int W = 4
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  logic [15:0] col;
  logic [15:0] carry;

  always_comb begin
    col   = '0;
    carry = '0;
    p_o   = '0;
    for (int k = 0; k < 2*W-1; k++) begin
      col = carry;
      for (int i = 0; i < W; i++) begin
        for (int j = 0; j < W; j++) begin
          if (i + j == k) col = col + 16'(a_i[i] & b_i[j]);
        end
      end
      p_o[k] = col[0];
      carry  = col >> 1;
    end
    p_o[2*W-1] = carry[0];
  end

endmodule

// File: rtl/vedic_seq_mul_ctrl.sv
// Sequential Vedic multiplier front end: four half-width sub-products summed over
// three cycles through an external 2N-bit adder. VEDIC_MUL_OVF_FLAG_EN adds ovf.
module vedic_seq_mul_ctrl
  import vedic_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic [2*N-1:0] add_a,
  output logic [2*N-1:0] add_b,
  output logic           add_cin,
  input  logic [2*N-1:0] add_sum,
  input  logic           add_cout,
`ifdef VEDIC_MUL_OVF_FLAG_EN
  output logic           ovf,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_p
);

  localparam int H        = half_w(N);
  localparam int P        = prod_w(N);
  localparam int SH_CROSS = sh_cross(N);
  localparam int SH_HIGH  = sh_high(N);

  state_e         state_q;
  logic [N-1:0]   a_q, b_q;
  logic [P-1:0]   acc_q, out_p_q;
  logic           in_ready_q, out_valid_q;
  logic [H-1:0]   ll_a, ll_b;
  logic [N-1:0]   p_ll, p_hl, p_lh, p_hh;

  // P_LL is consumed only at acceptance, before the operands are latched.
  assign ll_a = (state_q == S_IDLE) ? in_a[H-1:0] : a_q[H-1:0];
  assign ll_b = (state_q == S_IDLE) ? in_b[H-1:0] : b_q[H-1:0];

  vedic_half_mult #(.W(H)) u_ll (.a_i(ll_a),       .b_i(ll_b),       .p_o(p_ll));
  vedic_half_mult #(.W(H)) u_hl (.a_i(a_q[N-1:H]), .b_i(b_q[H-1:0]), .p_o(p_hl));
  vedic_half_mult #(.W(H)) u_lh (.a_i(a_q[H-1:0]), .b_i(b_q[N-1:H]), .p_o(p_lh));
  vedic_half_mult #(.W(H)) u_hh (.a_i(a_q[N-1:H]), .b_i(b_q[N-1:H]), .p_o(p_hh));

  always_comb begin
    add_b = '0;
    case (state_q)
      S_ACC1:  add_b = {{N{1'b0}}, p_hl} << SH_CROSS;
      S_ACC2:  add_b = {{N{1'b0}}, p_lh} << SH_CROSS;
      S_ACC3:  add_b = {{N{1'b0}}, p_hh} << SH_HIGH;
      default: add_b = '0;
    endcase
  end

  assign add_a     = acc_q;
  assign add_cin   = 1'b0;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      out_p_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          a_q        <= in_a;
          b_q        <= in_b;
          acc_q      <= {{N{1'b0}}, p_ll};
          in_ready_q <= 1'b0;
          state_q    <= S_ACC1;
        end
        S_ACC1: begin
          acc_q   <= add_sum;
          state_q <= S_ACC2;
        end
        S_ACC2: begin
          acc_q   <= add_sum;
          state_q <= S_ACC3;
        end
        S_ACC3: begin
          acc_q       <= add_sum;
          out_p_q     <= add_sum;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef VEDIC_MUL_OVF_FLAG_EN
  logic ovf_q;

  // Sticky carry leakage from the approximate adder, cleared on the next accept.
  always_ff @(posedge clk) begin
    if (!rst_n)
      ovf_q <= 1'b0;
    else if (state_q == S_IDLE && in_valid)
      ovf_q <= 1'b0;
    else if ((state_q == S_ACC1 || state_q == S_ACC2 || state_q == S_ACC3) && add_cout)
      ovf_q <= 1'b1;
  end

  assign ovf = ovf_q;
`else
  logic unused_cout;
  assign unused_cout = add_cout;
`endif

endmodule

// File: tb/tb_vedic_seq_mul_ctrl.sv
// Bench for vedic_seq_mul_ctrl: exact adder model, table vectors, scoreboard queue.
module tb_vedic_seq_mul_ctrl;

  localparam int N = 8;
  localparam int P = 16;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [P-1:0] p;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_a = '0, in_b = '0;
  logic [P-1:0] add_a, add_b, add_sum, out_p;
  logic         add_cin, add_cout, out_valid;
  logic         out_ready = 1'b1;
  logic         force_cout = 1'b0;
  logic [P:0]   add_full;
`ifdef VEDIC_MUL_OVF_FLAG_EN
  logic         ovf;
`endif

  int           n_chk = 0;
  int           n_fail = 0;
  logic [P-1:0] sb[$];
  vec_t         vt[10];

  always #5 clk = ~clk;

  assign add_full = {1'b0, add_a} + {1'b0, add_b} + {{P{1'b0}}, add_cin};
  assign add_sum  = add_full[P-1:0];
  assign add_cout = add_full[P] | force_cout;

  vedic_seq_mul_ctrl #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
`ifdef VEDIC_MUL_OVF_FLAG_EN
    .ovf(ovf),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p)
  );

  task automatic check(input string name, input logic [P-1:0] act, input logic [P-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("valid_ready_excl", 16'(out_valid & in_ready), 16'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_product", out_p, 16'hxxxx);
        else check("product", out_p, sb.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check("in_ready_timeout", 16'(in_ready), 16'd1);
  endtask

  task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b, input logic [P-1:0] exp);
    wait_ready();
    in_a = a; in_b = b; in_valid = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = N'($urandom); in_b = N'($urandom);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic run_vec(input logic [N-1:0] a, input logic [N-1:0] b, input logic [P-1:0] exp);
    int n;
    accept(a, b, exp);
    check("in_ready_busy", 16'(in_ready), 16'd0);
    wait_valid(n);
    // Three edges after the accepting edge: four cycles from operand presentation.
    check("latency", 16'(n), 16'd3);
    @(posedge clk); #1;
    check("in_ready_after", 16'(in_ready), 16'd1);
  endtask

  initial begin
    int n;
    logic [N-1:0] ra, rb;

    vt[0] = '{8'h0F, 8'h0F, 16'h00E1};
    vt[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vt[2] = '{8'h12, 8'h34, 16'h03A8};
    vt[3] = '{8'hA5, 8'h00, 16'h0000};
    vt[4] = '{8'h00, 8'h00, 16'h0000};
    vt[5] = '{8'h01, 8'h01, 16'h0001};
    vt[6] = '{8'h80, 8'h80, 16'h4000};
    vt[7] = '{8'hFF, 8'h01, 16'h00FF};
    vt[8] = '{8'h0F, 8'hF0, 16'h0E10};
    vt[9] = '{8'hAA, 8'h55, 16'h3872};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_p", out_p, 16'h0000);
    check("rst_add_a", add_a, 16'h0000);
    check("rst_add_b", add_b, 16'h0000);
    check("add_cin", 16'(add_cin), 16'd0);
    rst_n = 1'b1;

    foreach (vt[i]) run_vec(vt[i].a, vt[i].b, vt[i].p);

    // Adder operand sequence for 0xFF * 0xFF
    accept(8'hFF, 8'hFF, 16'hFE01);
    check("s1_add_a", add_a, 16'h00E1);
    check("s1_add_b", add_b, 16'h0E10);
    @(posedge clk); #1;
    check("s2_add_a", add_a, 16'h0EF1);
    check("s2_add_b", add_b, 16'h0E10);
    @(posedge clk); #1;
    check("s3_add_a", add_a, 16'h1D01);
    check("s3_add_b", add_b, 16'hE100);
    @(posedge clk); #1;
    check("s4_out_valid", 16'(out_valid), 16'd1);
    check("s4_out_p", out_p, 16'hFE01);
    check("s4_add_b", add_b, 16'h0000);
    @(posedge clk); #1;
    check("s4_in_ready", 16'(in_ready), 16'd1);

    // Backpressure with an ignored second request
    out_ready = 1'b0;
    accept(8'hA5, 8'h00, 16'h0000);
    wait_valid(n);
    check("bp_latency", 16'(n), 16'd3);
    in_a = 8'hFF; in_b = 8'hFF; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 16'(out_valid), 16'd1);
      check("bp_out_p", out_p, 16'h0000);
      check("bp_in_ready", 16'(in_ready), 16'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", 16'(in_ready), 16'd1);
    check("bp_release_valid", 16'(out_valid), 16'd0);
    repeat (6) @(posedge clk);
    #1;
    check("bp_no_stray", 16'(out_valid), 16'd0);

    // Reset during ACC2 aborts the product
    accept(8'h12, 8'h34, 16'h03A8);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    check("abort_out_valid", 16'(out_valid), 16'd0);
    check("abort_out_p", out_p, 16'h0000);
    check("abort_in_ready", 16'(in_ready), 16'd1);
    repeat (5) @(posedge clk);
    #1;
    check("abort_quiet", 16'(out_valid), 16'd0);
    run_vec(8'h12, 8'h34, 16'h03A8);

    // Random operands against a reference product
    for (int i = 0; i < 8; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      run_vec(ra, rb, 16'(ra) * 16'(rb));
    end

`ifdef VEDIC_MUL_OVF_FLAG_EN
    accept(8'h3C, 8'h5A, 16'h1518);
    @(posedge clk); #1;
    force_cout = 1'b1;
    @(posedge clk); #1;
    force_cout = 1'b0;
    wait_valid(n);
    check("ovf_set", 16'(ovf), 16'd1);
    @(posedge clk); #1;
    accept(8'h03, 8'h05, 16'h000F);
    check("ovf_clear", 16'(ovf), 16'd0);
    wait_valid(n);
    check("ovf_still_clear", 16'(ovf), 16'd0);
    @(posedge clk); #1;
`endif

    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
